// File: rtl/cheri_data_mem_responder.sv
// Memory-side responder for the core data bus (req/gnt/rvalid) backed by a
// tagged 33-bit word array. It grants requests while the outstanding budget
// allows, commits byte-enabled writes with capability tag handling, and
// returns in-order responses after a fixed latency.
module cheri_data_mem_responder #(
  parameter logic [31:0] AddrBase       = 32'h2000_0000,
  parameter int          SizeWords      = 16384,
  parameter int          RespLatency    = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,
  input  logic        gnt_stall_i,
  output logic [15:0] err_cnt_o
);

  localparam int          IdxW  = $clog2(SizeWords);
  localparam int          CntW  = 3;
  localparam logic [32:0] WinLo = {1'b0, AddrBase};
  localparam logic [32:0] WinHi = WinLo + (33'(SizeWords) << 2);

  // One entry of the response pipeline.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [32:0] rdata;
  } resp_t;

  logic [32:0]     mem_q  [SizeWords];
  resp_t           pipe_q [RespLatency];
  resp_t           pipe_d [RespLatency];
  logic [CntW-1:0] out_q, out_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            accept;
  logic            in_range;
  logic [32:0]     addr_full;
  logic [32:0]     addr_off;
  logic [IdxW-1:0] word_idx;
  logic            rvalid;
  resp_t           new_resp;
  resp_t           last_resp;
  logic            unused_bits;

  // Address decode: 33-bit compare so the window end cannot wrap.
  assign addr_full = {1'b0, data_addr_i};
  assign in_range  = (addr_full >= WinLo) && (addr_full < WinHi);
  assign addr_off  = addr_full - WinLo;
  assign word_idx  = addr_off[IdxW+1:2];

  // Integrity input and the out-of-window offset bits carry no information here.
  assign unused_bits = ^{data_wdata_intg_i, addr_off[32:IdxW+2], addr_off[1:0]};

  // Grant is purely combinational and suppressed during reset.
  assign data_gnt_o = data_req_i & ~gnt_stall_i & ~rst_i &
                      (out_q < CntW'(MaxOutstanding));
  assign accept     = data_req_i & data_gnt_o;

  // Response outputs come from the last pipeline stage, masked during reset
  // so no pre-reset response escapes.
  assign last_resp         = pipe_q[RespLatency-1];
  assign rvalid            = last_resp.valid & ~rst_i;
  assign data_rvalid_o     = rvalid;
  assign data_err_o        = last_resp.err & ~rst_i;
  assign data_rdata_o      = rst_i ? 33'h0 : last_resp.rdata;
  assign data_rdata_intg_o = 7'h0;
  assign err_cnt_o         = err_cnt_q;

  // Build the response for this cycle's request and shift the pipeline.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    new_resp = '0;
    if (accept) begin
      new_resp.valid = 1'b1;
      new_resp.err   = ~in_range;
      if (in_range && !data_we_i) begin
        new_resp.rdata = mem_q[word_idx];
      end
    end
    pipe_d[0] = new_resp;
    for (int i = 1; i < RespLatency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Outstanding counter and saturating error count next-state.
  always_comb begin
    out_d = out_q;
    unique case ({accept, rvalid})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    err_cnt_d = err_cnt_q;
    // The count moves in step with the error response reaching the output.
    if (pipe_d[RespLatency-1].valid && pipe_d[RespLatency-1].err &&
        err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Control state: response pipeline, outstanding counter, error count.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst_i) begin
      for (int i = 0; i < RespLatency; i++) begin
        pipe_q[i] <= '0;
      end
      out_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      pipe_q    <= pipe_d;
      out_q     <= out_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Tagged array write: byte lanes by enable, tag kept only on a full-word write.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset; contents persist and only control state is cleared.
    if (accept && data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem_q[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
      mem_q[word_idx][32] <= (data_be_i == 4'hF) ? data_wdata_i[32] : 1'b0;
    end
  end

endmodule

// File: tb/tb_cheri_data_mem_responder.sv
// Scoreboard bench for cheri_data_mem_responder: one instance at latency 1
// for data, error, stall and reset behaviour, one at latency 3 for grant
// backpressure against the outstanding limit.
module tb_cheri_data_mem_responder;

  localparam logic [31:0] Base = 32'h2000_0000;

  typedef struct {
    logic        err;
    logic [32:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 instance.
  logic        rst, req, gnt, we, rvalid, err, stall;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wdata, rdata;
  logic [6:0]  rintg;
  logic [15:0] err_cnt;

  // Latency-3 instance.
  logic        rst3, req3, gnt3, we3, rvalid3, err3;
  logic [3:0]  be3;
  logic [31:0] addr3;
  logic [32:0] wdata3, rdata3;
  logic [6:0]  rintg3;
  logic [15:0] err_cnt3;

  cheri_data_mem_responder #(.RespLatency(1), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_wdata_intg_i(7'h0),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_rdata_intg_o(rintg),
    .data_err_o(err), .gnt_stall_i(stall), .err_cnt_o(err_cnt)
  );

  cheri_data_mem_responder #(.RespLatency(3), .MaxOutstanding(2)) dut3 (
    .clk_i(clk), .rst_i(rst3), .data_req_i(req3), .data_gnt_o(gnt3), .data_we_i(we3),
    .data_be_i(be3), .data_addr_i(addr3), .data_wdata_i(wdata3), .data_wdata_intg_i(7'h0),
    .data_rvalid_o(rvalid3), .data_rdata_o(rdata3), .data_rdata_intg_o(rintg3),
    .data_err_o(err3), .gnt_stall_i(1'b0), .err_cnt_o(err_cnt3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model state.
  exp_t        q[$];
  exp_t        q3[$];
  logic [32:0] mdl [int];
  logic [15:0] exp_err_cnt = 16'h0;
  bit          sb_en = 1'b1;

  function automatic bit in_rng(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, Base}) && ({1'b0, a} < ({1'b0, Base} + 33'h1_0000));
  endfunction

  function automatic logic [32:0] merge(input logic [32:0] old, input logic [3:0] b,
                                        input logic [32:0] wd);
    logic [32:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
    r[32] = (b == 4'hF) ? wd[32] : 1'b0;
    return r;
  endfunction

  // Drive one request on the latency-1 instance; entered and left at posedge+1.
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [32:0] wd);
    exp_t e;
    int   waited;
    int   key;
    bit   done;
    waited = 0;
    done   = 1'b0;
    req = 1'b1; we = w; be = b; addr = a; wdata = wd;
    while (!done) begin
      @(negedge clk);
      if (gnt) begin
        done = 1'b1;
        if (sb_en) begin
          e.due = cyc + 1;
          e.rdata = 33'h0;
          e.err = 1'b0;
          if (!in_rng(a)) begin
            e.err = 1'b1;
            if (exp_err_cnt != 16'hFFFF) exp_err_cnt++;
          end else begin
            key = int'((a - Base) >> 2);
            if (w) mdl[key] = merge(mdl.exists(key) ? mdl[key] : 33'hx, b, wd);
            else   e.rdata = mdl.exists(key) ? mdl[key] : 33'hx;
          end
          q.push_back(e);
        end
      end else if (++waited > 50) begin
        check("gnt_timeout", 0, 1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  // Wait for every expected response of the latency-1 instance.
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // Full-word write on the latency-3 instance; the write response is scoreboarded.
  task automatic write3(input logic [31:0] a, input logic [32:0] wd);
    exp_t e;
    int   waited;
    waited = 0;
    req3 = 1'b1; we3 = 1'b1; be3 = 4'hF; addr3 = a; wdata3 = wd;
    forever begin
      @(negedge clk);
      if (gnt3) begin
        e.due = cyc + 3; e.err = 1'b0; e.rdata = 33'h0;
        q3.push_back(e);
        @(posedge clk); #1;
        break;
      end
      if (++waited > 50) begin
        check("gnt3_timeout", 0, 1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    req3 = 1'b0;
  endtask

  // Response monitors.
  exp_t me;
  always @(negedge clk) begin
    if (sb_en && rvalid) begin
      if (q.size() == 0) begin
        check("unexpected_rvalid", 1, 0);
      end else begin
        me = q.pop_front();
        check("resp_cycle", cyc, me.due);
        check("resp_err", err, me.err);
        check("resp_rdata", rdata, me.rdata);
        check("resp_intg", rintg, 0);
      end
    end
  end

  exp_t me3;
  always @(negedge clk) begin
    if (rvalid3) begin
      if (q3.size() == 0) begin
        check("unexpected_rvalid3", 1, 0);
      end else begin
        me3 = q3.pop_front();
        check("resp3_cycle", cyc, me3.due);
        check("resp3_err", err3, me3.err);
        check("resp3_rdata", rdata3, me3.rdata);
      end
    end
  end

  // Requester rule: attributes and req stay put while waiting for a grant.
  logic        p_req, p_gnt, p_rst;
  logic [69:0] p_attr;
  initial begin p_req = 1'b0; p_gnt = 1'b0; p_rst = 1'b1; p_attr = '0; end
  always @(posedge clk) begin
    if (p_req && !p_gnt && !p_rst) begin
      check("proto_req_held", req, 1);
      check("proto_attr_stable", {we, be, addr, wdata}, p_attr);
    end
    p_req  = req;
    p_gnt  = gnt;
    p_rst  = rst;
    p_attr = {we, be, addr, wdata};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [32:0] rd_exp [4];
    bit          g [8];
    int          k;
    int          t;
    exp_t        e;

    rst = 1'b1; rst3 = 1'b1; stall = 1'b0;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = Base; wdata = '0;
    req3 = 1'b0; we3 = 1'b0; be3 = 4'hF; addr3 = Base; wdata3 = '0;

    // Reset state, with a request pending to show grant is held off.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0; rst3 = 1'b0; req = 1'b0;

    // Full write then back-to-back read of the same word.
    issue(1'b1, 4'hF, 32'h2000_0010, {1'b1, 32'hDEAD_BEEF});
    issue(1'b0, 4'hF, 32'h2000_0010, '0);
    drain();

    // Partial write clears the tag; a zero byte-enable write clears only the tag.
    issue(1'b1, 4'b0010, 32'h2000_0010, 33'h0_0000_5500);
    issue(1'b0, 4'hF, 32'h2000_0010, '0);
    issue(1'b1, 4'hF, 32'h2000_0020, {1'b1, 32'h1111_2222});
    issue(1'b1, 4'h0, 32'h2000_0020, {1'b1, 32'hFFFF_FFFF});
    issue(1'b0, 4'hF, 32'h2000_0020, '0);
    drain();
    check("partial_model", mdl[4], 33'h0_DEAD_55EF);

    // Window edges, then out-of-range read and write.
    issue(1'b1, 4'hF, 32'h2000_0000, {1'b1, 32'h1234_5678});
    issue(1'b1, 4'hF, 32'h2000_FFFC, {1'b1, 32'hFEED_F00D});
    issue(1'b0, 4'hF, 32'h2000_FFFC, '0);
    issue(1'b0, 4'hF, 32'h1FFF_FFFC, '0);
    issue(1'b1, 4'hF, 32'h2001_0000, {1'b1, 32'hCAFE_BABE});
    drain();
    check("oor_err_cnt", err_cnt, 16'd2);
    issue(1'b0, 4'hF, 32'h2000_0000, '0);
    issue(1'b0, 4'hF, 32'h2000_FFFC, '0);
    drain();
    check("err_cnt_model", exp_err_cnt, 16'd2);

    // Backpressure at latency 3: prime four words, then a held read burst.
    for (int i = 0; i < 4; i++) begin
      rd_exp[i] = {1'(i & 1), 32'hA5A5_0000 + 32'(i)};
      write3(Base + 32'h40 + 32'(4 * i), rd_exp[i]);
    end
    repeat (6) @(posedge clk);
    #1;
    check("drain3_empty", q3.size(), 0);
    k = 0; t = 0;
    req3 = 1'b1; we3 = 1'b0; be3 = 4'hF; addr3 = Base + 32'h40;
    while (k < 4 && t < 40) begin
      @(negedge clk);
      if (t < 8) g[t] = gnt3;
      if (gnt3) begin
        e.due = cyc + 3; e.err = 1'b0; e.rdata = rd_exp[k];
        q3.push_back(e);
        k++;
      end
      @(posedge clk); #1;
      if (k < 4) addr3 = Base + 32'h40 + 32'(4 * k);
      else       req3 = 1'b0;
      t++;
    end
    req3 = 1'b0;
    check("burst_count", k, 4);
    check("burst_gnt0", g[0], 1);
    check("burst_gnt1", g[1], 1);
    check("burst_gnt2", g[2], 0);
    check("burst_gnt3", g[3], 0);
    check("burst_gnt4", g[4], 1);
    repeat (6) @(posedge clk);
    #1;
    check("burst_drain", q3.size(), 0);

    // Stall with request held, then two grants and a reset right after.
    sb_en = 1'b0;
    stall = 1'b1;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h2000_0010; wdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_gnt", gnt, 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    issue(1'b0, 4'hF, 32'h2000_0010, '0);
    issue(1'b0, 4'hF, 32'h2000_0020, '0);
    rst = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h2000_0010; wdata = 33'h0;
    @(negedge clk);
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_rvalid", rvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    exp_err_cnt = 16'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", rvalid, 0);
    end
    check("post_rst_outstanding", dut.out_q, 0);
    check("post_rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    sb_en = 1'b1;
    issue(1'b0, 4'hF, 32'h2000_0010, '0);
    drain();

    // Saturation of the error counter.
    force dut.err_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.err_cnt_q;
    exp_err_cnt = 16'hFFFE;
    check("sat_preload", err_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) issue(1'b0, 4'hF, 32'h3000_0000 + 32'(4 * i), '0);
    drain();
    check("sat_err_cnt", err_cnt, exp_err_cnt);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", err_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
